// File: rtl/strategy_scheduler.sv
// strategy_scheduler
//   Round-robin scheduler that time-shares one strategy_imbalance engine
//   across NUM_INST instruments. Book updates mark an instrument pending;
//   each grant runs a fixed sequence: book RAM read, engine enable, result
//   capture, and (if the engine produced an order) a downstream handoff.
//   An accepted order starts a per-instrument cooldown that blocks further
//   grants of that instrument until it counts down to zero.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   sched_en            1 = new grants allowed; 0 = only finish in-flight work
//   upd_valid/upd_inst  book update strobe and instrument (>= NUM_INST ignored)
//   cfg_cooldown        cooldown cycles loaded when an order is accepted
//   book_rd_en/_inst    book RAM read strobe and address (data 1 cycle later)
//   strat_enable/_inst  engine enable pulse and instrument id
//   strat_valid/side/price/qty/inst_out   engine result
//   ord_valid/ord_ready order handshake to the encoder
//   ord_side/price/qty/inst               order payload
//   busy                sequence in progress
//   mismatch_err        sticky: engine answered for a different instrument
//   state_dbg           current FSM state (debug)
//   pending_dbg         pending bitmap (debug)
//
// Order handshake: ord_valid rises with a stable payload and stays high,
// payload unchanged, until the cycle in which ord_valid && ord_ready; that
// cycle is the transfer. ord_valid never drops without a transfer except on
// reset.

`ifndef PRICE_W
`define PRICE_W 32
`endif
`ifndef SIZE_W
`define SIZE_W 16
`endif

module strategy_scheduler #(
   parameter int NUM_INST = 8,
   parameter int IDX_W    = 3,
   parameter int CD_W     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sched_en,
   input  logic                upd_valid,
   input  logic [IDX_W-1:0]    upd_inst,
   input  logic [CD_W-1:0]     cfg_cooldown,
   output logic                book_rd_en,
   output logic [IDX_W-1:0]    book_rd_inst,
   output logic                strat_enable,
   output logic [IDX_W-1:0]    strat_inst,
   input  logic                strat_valid,
   input  logic                strat_side,
   input  logic [`PRICE_W-1:0] strat_price,
   input  logic [`SIZE_W-1:0]  strat_qty,
   input  logic [IDX_W-1:0]    strat_inst_out,
   output logic                ord_valid,
   input  logic                ord_ready,
   output logic                ord_side,
   output logic [`PRICE_W-1:0] ord_price,
   output logic [`SIZE_W-1:0]  ord_qty,
   output logic [IDX_W-1:0]    ord_inst,
   output logic                busy,
   output logic                mismatch_err,
   output logic [2:0]          state_dbg,
   output logic [NUM_INST-1:0] pending_dbg
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_EVAL = 3'd2,
      S_RESP = 3'd3,
      S_OUT  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    g_q;
   logic [IDX_W-1:0]    last_q;
   logic [NUM_INST-1:0] pending_q, pending_d;
   logic [NUM_INST-1:0] eligible;
   logic [CD_W-1:0]     cd_q [NUM_INST];

   logic [IDX_W-1:0]    start;
   logic [NUM_INST-1:0] elig_rot;
   logic                found;
   logic [IDX_W-1:0]    pick;
   int                  cand;

   logic                grant, accept, resp_ok, resp_bad;

   always_comb begin
      for (int i = 0; i < NUM_INST; i++) begin
         eligible[i] = pending_q[i] && (cd_q[i] == '0);
      end
   end

   // Rotate the eligible set so bit 0 is the instrument after last_grant,
   // take the lowest set bit, then map back to an absolute index. start can
   // equal NUM_INST when NUM_INST is not a power of two; the doubled vector
   // and the subtraction below cover that wrap.
   assign start    = last_q + IDX_W'(1);
   assign elig_rot = NUM_INST'({eligible, eligible} >> start);

   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = 0;
      for (int j = 0; j < NUM_INST; j++) begin
         if (!found && elig_rot[j]) begin
            found = 1'b1;
            cand  = int'(start) + j;
            if (cand >= NUM_INST) cand = cand - NUM_INST;
            pick  = IDX_W'(cand);
         end
      end
   end

   assign grant  = (state_q == S_IDLE) && sched_en && found;
   assign accept = (state_q == S_OUT) && ord_ready;
   // inst_out is only meaningful alongside strat_valid, so a mismatch is
   // only flagged on a valid result.
   assign resp_bad = (state_q == S_RESP) && strat_valid && (strat_inst_out != g_q);
   assign resp_ok  = (state_q == S_RESP) && strat_valid && (strat_inst_out == g_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant) state_d = S_READ;
         S_READ:  state_d = S_EVAL;
         S_EVAL:  state_d = S_RESP;
         S_RESP:  state_d = resp_ok ? S_OUT : S_IDLE;
         S_OUT:   if (ord_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Clear on grant first so a same-cycle update re-marks the instrument.
   always_comb begin
      pending_d = pending_q;
      if (grant) pending_d[pick] = 1'b0;
      if (upd_valid && (int'(upd_inst) < NUM_INST)) pending_d[upd_inst] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         g_q          <= '0;
         last_q       <= IDX_W'(NUM_INST - 1);
         pending_q    <= '0;
         for (int i = 0; i < NUM_INST; i++) cd_q[i] <= '0;
         book_rd_en   <= 1'b0;
         book_rd_inst <= '0;
         strat_enable <= 1'b0;
         strat_inst   <= '0;
         ord_valid    <= 1'b0;
         ord_side     <= 1'b0;
         ord_price    <= '0;
         ord_qty      <= '0;
         ord_inst     <= '0;
         busy         <= 1'b0;
         mismatch_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         if (grant) begin
            g_q    <= pick;
            last_q <= pick;
         end

         // Outputs are registered from the next state so each one is high
         // exactly while the FSM sits in the matching state.
         book_rd_en   <= (state_d == S_READ);
         if (grant) book_rd_inst <= pick;
         strat_enable <= (state_d == S_EVAL);
         if (state_q == S_READ) strat_inst <= g_q;
         ord_valid    <= (state_d == S_OUT);
         busy         <= (state_d != S_IDLE);

         if (resp_ok) begin
            ord_side  <= strat_side;
            ord_price <= strat_price;
            ord_qty   <= strat_qty;
            ord_inst  <= g_q;
         end
         if (resp_bad) mismatch_err <= 1'b1;

         // A load on accept takes priority over that cycle's decrement.
         for (int i = 0; i < NUM_INST; i++) begin
            if (accept && (g_q == IDX_W'(i))) cd_q[i] <= cfg_cooldown;
            else if (cd_q[i] != '0)          cd_q[i] <= cd_q[i] - CD_W'(1);
         end
      end
   end

   assign state_dbg   = state_q;
   assign pending_dbg = pending_q;

endmodule
